// File: rtl/multi_sprite_blitter_if.sv
// Signal bundle between the blitter, the game controller, the sprite/background ROMs and the VGA adapter.
// slave = blitter side, master = controller/ROM/VGA side.
interface multi_sprite_blitter_if #(
    parameter int NUM_SPRITES = 2,
    parameter int SPR_W       = 44,
    parameter int SPR_H       = 100,
    parameter int SCR_W       = 160,
    parameter int SCR_H       = 120,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int COLOR_W     = 9
);
    localparam int SELW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int SPR_AW = $clog2(SPR_W * SPR_H);
    localparam int SCR_AW = $clog2(SCR_W * SCR_H);

    logic                      start;
    logic [1:0]                mode;
    logic [NUM_SPRITES-1:0]    spr_en;
    logic [NUM_SPRITES*XW-1:0] spr_x;
    logic [NUM_SPRITES*YW-1:0] spr_y;
    logic [SELW-1:0]           sprite_sel;
    logic [SPR_AW-1:0]         sprite_rom_addr;
    logic [COLOR_W-1:0]        sprite_rom_data;
    logic [SCR_AW-1:0]         bkgd_rom_addr;
    logic [COLOR_W-1:0]        bkgd_rom_data;
    logic [XW-1:0]             x_out;
    logic [YW-1:0]             y_out;
    logic [COLOR_W-1:0]        colour_out;
    logic                      plot;
    logic                      busy;
    logic                      done;

    modport slave (
        input  start, mode, spr_en, spr_x, spr_y, sprite_rom_data, bkgd_rom_data,
        output sprite_sel, sprite_rom_addr, bkgd_rom_addr, x_out, y_out, colour_out,
               plot, busy, done
    );

    modport master (
        output start, mode, spr_en, spr_x, spr_y, sprite_rom_data, bkgd_rom_data,
        input  sprite_sel, sprite_rom_addr, bkgd_rom_addr, x_out, y_out, colour_out,
               plot, busy, done
    );
endinterface

// File: rtl/multi_sprite_blitter.sv
// One-pixel-per-clock sprite/screen scanner feeding ROM addresses and VGA plot writes.
// Optional SPRITE_CLIP_EN: suppress plots for off-screen pixels instead of wrapping coordinates.
//
//  state | meaning
//  IDLE  | waiting for start; pass configuration captured on start
//  SCAN  | one ROM address issued per cycle
//  FLUSH | ROM/pipeline drain, ROM_LATENCY+1 cycles
//  DONE  | one-cycle done pulse
module multi_sprite_blitter #(
    parameter int                 NUM_SPRITES = 2,
    parameter int                 SPR_W       = 44,
    parameter int                 SPR_H       = 100,
    parameter int                 SCR_W       = 160,
    parameter int                 SCR_H       = 120,
    parameter int                 XW          = 8,
    parameter int                 YW          = 7,
    parameter int                 COLOR_W     = 9,
    parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
    parameter int                 ROM_LATENCY = 1
) (
    input  logic                 clk_50,
    input  logic                 reset,
    multi_sprite_blitter_if.slave bus
);
    localparam int SELW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int SPR_AW = $clog2(SPR_W * SPR_H);
    localparam int SCR_AW = $clog2(SCR_W * SCR_H);
    localparam int CW     = $clog2(((SPR_W > SCR_W) ? SPR_W : SCR_W) + 1);
    localparam int RW     = $clog2(((SPR_H > SCR_H) ? SPR_H : SCR_H) + 1);
    localparam int FW     = $clog2(ROM_LATENCY + 1);
    localparam int XW1    = XW + 1;
    localparam int YW1    = YW + 1;
    localparam int LAST   = ROM_LATENCY - 1;
    localparam logic [1:0] MODE_DRAW = 2'b00;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [NUM_SPRITES-1:0]    en_q, en_d;
    logic [NUM_SPRITES*XW-1:0] sx_q, sx_d;
    logic [NUM_SPRITES*YW-1:0] sy_q, sy_d;
    logic [SELW-1:0]           sel_q, sel_d;
    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             row_q, row_d;
    logic [FW-1:0]             fcnt_q, fcnt_d;

    logic                      vld_q  [ROM_LATENCY];
    logic [XW-1:0]             px_q   [ROM_LATENCY];
    logic [YW-1:0]             py_q   [ROM_LATENCY];
    logic [1:0]                ptag_q [ROM_LATENCY];
`ifdef SPRITE_CLIP_EN
    logic                      pclip_q [ROM_LATENCY];
    logic                      clip_now;
`endif

    logic [XW-1:0]             x_out_q;
    logic [YW-1:0]             y_out_q;
    logic [COLOR_W-1:0]        colour_q;
    logic                      plot_q, plot_d;

    logic                      is_fill, last_col, last_row, scan_last, draw_px;
    logic [XW-1:0]             org_x;
    logic [YW-1:0]             org_y;
    logic [XW1-1:0]            x_w;
    logic [YW1-1:0]            y_w;
    logic [SELW:0]             first, nxt;
    logic [COLOR_W-1:0]        pix_colour;

    // {found, index} of the lowest enabled sprite at or above 'from'
    function automatic logic [SELW:0] find_en(input logic [NUM_SPRITES-1:0] en, input int from);
        find_en = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (i >= from && en[i]) find_en = {1'b1, SELW'(i)};
        end
    endfunction

    assign is_fill = mode_q[1];
    assign org_x   = sx_q[int'(sel_q) * XW +: XW];
    assign org_y   = sy_q[int'(sel_q) * YW +: YW];
    assign x_w     = is_fill ? XW1'(col_q) : XW1'(org_x) + XW1'(col_q);
    assign y_w     = is_fill ? YW1'(row_q) : YW1'(org_y) + YW1'(row_q);
    assign first   = find_en(bus.spr_en, 0);
    assign nxt     = find_en(en_q, int'(sel_q) + 1);
    assign last_col  = is_fill ? (col_q == CW'(SCR_W - 1)) : (col_q == CW'(SPR_W - 1));
    assign last_row  = is_fill ? (row_q == RW'(SCR_H - 1)) : (row_q == RW'(SPR_H - 1));
    assign scan_last = last_col && last_row && (is_fill || !nxt[SELW]);
`ifdef SPRITE_CLIP_EN
    assign clip_now  = (x_w >= XW1'(SCR_W)) || (y_w >= YW1'(SCR_H));
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        en_d    = en_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        sel_d   = sel_q;
        col_d   = col_q;
        row_d   = row_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    en_d    = bus.spr_en;
                    sx_d    = bus.spr_x;
                    sy_d    = bus.spr_y;
                    sel_d   = first[SELW-1:0];
                    col_d   = '0;
                    row_d   = '0;
                    fcnt_d  = FW'(ROM_LATENCY);
                    // no enabled sprite: skip straight to the drain
                    state_d = (bus.mode[1] || first[SELW]) ? SCAN : FLUSH;
                end
            end
            SCAN: begin
                if (!last_col) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = '0;
                    if (!last_row) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        row_d = '0;
                        sel_d = nxt[SELW-1:0];
                    end
                end
                if (scan_last) state_d = FLUSH;
            end
            FLUSH: begin
                if (fcnt_q == '0) state_d = DONE;
                else              fcnt_d  = fcnt_q - 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        draw_px    = (ptag_q[LAST] == MODE_DRAW);
        pix_colour = draw_px ? bus.sprite_rom_data : bus.bkgd_rom_data;
        plot_d     = vld_q[LAST] && !(draw_px && (pix_colour == TRANSPARENT));
`ifdef SPRITE_CLIP_EN
        if (pclip_q[LAST]) plot_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            en_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            sel_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fcnt_q   <= '0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                vld_q[i]  <= 1'b0;
                px_q[i]   <= '0;
                py_q[i]   <= '0;
                ptag_q[i] <= '0;
`ifdef SPRITE_CLIP_EN
                pclip_q[i] <= 1'b0;
`endif
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sel_q   <= sel_d;
            col_q   <= col_d;
            row_q   <= row_d;
            fcnt_q  <= fcnt_d;
            // coordinates travel alongside the ROM read so they line up with its data
            vld_q[0]  <= (state_q == SCAN);
            px_q[0]   <= x_w[XW-1:0];
            py_q[0]   <= y_w[YW-1:0];
            ptag_q[0] <= mode_q;
`ifdef SPRITE_CLIP_EN
            pclip_q[0] <= clip_now;
`endif
            for (int i = 1; i < ROM_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                px_q[i]   <= px_q[i-1];
                py_q[i]   <= py_q[i-1];
                ptag_q[i] <= ptag_q[i-1];
`ifdef SPRITE_CLIP_EN
                pclip_q[i] <= pclip_q[i-1];
`endif
            end
            plot_q <= plot_d;
            if (plot_d) begin
                x_out_q  <= px_q[LAST];
                y_out_q  <= py_q[LAST];
                colour_q <= pix_colour;
            end
        end
    end

    assign bus.sprite_sel      = sel_q;
    assign bus.sprite_rom_addr = SPR_AW'(32'(row_q) * SPR_W + 32'(col_q));
    assign bus.bkgd_rom_addr   = SCR_AW'(32'(y_w) * SCR_W + 32'(x_w));
    assign bus.x_out           = x_out_q;
    assign bus.y_out           = y_out_q;
    assign bus.colour_out      = colour_q;
    assign bus.plot            = plot_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.done            = (state_q == DONE);
endmodule

// File: tb/tb_multi_sprite_blitter.sv
// Scoreboard bench for multi_sprite_blitter: a pixel-list reference model feeds a queue
// that an independent monitor drains on every plot.
module tb_multi_sprite_blitter;
    localparam int NS = 2, SW = 4, SH = 2, CW = 8, CH = 4, XW = 3, YW = 2, COLW = 9, LAT = 1;

    typedef struct packed {
        logic [XW-1:0]   x;
        logic [YW-1:0]   y;
        logic [COLW-1:0] c;
    } pix_t;

    typedef struct {
        int sel;
        int saddr;
        int baddr;
    } adr_t;

    logic clk_50 = 1'b0;
    logic reset;
    always #10 clk_50 = ~clk_50;

    multi_sprite_blitter_if #(
        .NUM_SPRITES(NS), .SPR_W(SW), .SPR_H(SH), .SCR_W(CW), .SCR_H(CH),
        .XW(XW), .YW(YW), .COLOR_W(COLW)
    ) bus ();

    multi_sprite_blitter #(
        .NUM_SPRITES(NS), .SPR_W(SW), .SPR_H(SH), .SCR_W(CW), .SCR_H(CH),
        .XW(XW), .YW(YW), .COLOR_W(COLW), .TRANSPARENT(9'h000), .ROM_LATENCY(LAT)
    ) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus)
    );

    logic [COLW-1:0] spr_mem  [NS*SW*SH];
    logic [COLW-1:0] bkgd_mem [CW*CH];

    // single-cycle synchronous ROMs
    always @(posedge clk_50) begin
        bus.sprite_rom_data <= spr_mem[{bus.sprite_sel, bus.sprite_rom_addr}];
        bus.bkgd_rom_data   <= bkgd_mem[bus.bkgd_rom_addr];
    end

    int   checks = 0;
    int   errors = 0;
    int   plots_seen = 0;
    pix_t exp_q[$];
    adr_t adr_q[$];
    pix_t last_pix = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: enumerate the pass pixel by pixel from the sprite/screen geometry.
    task automatic build_expect(input logic [1:0] m, input logic [1:0] en,
                                input int sx0, input int sy0, input int sx1, input int sy1,
                                output int p);
        int   sx[2];
        int   sy[2];
        int   x, y, ba;
        bit   pl;
        pix_t pe;
        adr_t ae;
        sx[0] = sx0; sx[1] = sx1;
        sy[0] = sy0; sy[1] = sy1;
        p = 0;
        if (m[1]) begin
            for (int yy = 0; yy < CH; yy++) begin
                for (int xx = 0; xx < CW; xx++) begin
                    p++;
                    ae.sel = -1; ae.saddr = -1; ae.baddr = yy * CW + xx;
                    adr_q.push_back(ae);
                    pe.x = XW'(xx); pe.y = YW'(yy); pe.c = bkgd_mem[yy * CW + xx];
                    exp_q.push_back(pe);
                end
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (en[i]) begin
                    for (int r = 0; r < SH; r++) begin
                        for (int c = 0; c < SW; c++) begin
                            p++;
                            x  = sx[i] + c;
                            y  = sy[i] + r;
                            ba = (y * CW + x) % (CW * CH);
                            ae.sel = i; ae.saddr = r * SW + c; ae.baddr = ba;
                            adr_q.push_back(ae);
                            pe.x = XW'(x % (1 << XW));
                            pe.y = YW'(y % (1 << YW));
                            pe.c = (m == 2'b00) ? spr_mem[i * SW * SH + r * SW + c] : bkgd_mem[ba];
                            pl   = !((m == 2'b00) && (pe.c == 9'h000));
`ifdef SPRITE_CLIP_EN
                            if (x >= CW || y >= CH) pl = 1'b0;
`endif
                            if (pl) exp_q.push_back(pe);
                        end
                    end
                end
            end
        end
    endtask

    task automatic start_pass(input logic [1:0] m, input logic [1:0] en,
                              input int sx0, input int sy0, input int sx1, input int sy1,
                              output int p);
        @(negedge clk_50);
        bus.mode   = m;
        bus.spr_en = en;
        bus.spr_x  = {XW'(sx1), XW'(sx0)};
        bus.spr_y  = {YW'(sy1), YW'(sy0)};
        build_expect(m, en, sx0, sy0, sx1, sy1, p);
        bus.start  = 1'b1;
        @(posedge clk_50);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input logic [1:0] m, input logic [1:0] en,
                            input int sx0, input int sy0, input int sx1, input int sy1,
                            input bit poke);
        int   p, done_at, busy_n, ps0, exp_plots;
        adr_t a;
        ps0 = plots_seen;
        start_pass(m, en, sx0, sy0, sx1, sy1, p);
        exp_plots = exp_q.size();
        done_at   = -1;
        busy_n    = 0;
        for (int k = 1; k <= p + LAT + 8; k++) begin
            @(negedge clk_50);
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1 && done_at < 0) done_at = k;
            if (k <= p && adr_q.size() > 0) begin
                a = adr_q.pop_front();
                if (a.sel >= 0) begin
                    chk({tag, " sprite_sel"}, 32'(bus.sprite_sel), a.sel);
                    chk({tag, " sprite_addr"}, 32'(bus.sprite_rom_addr), a.saddr);
                end
                chk({tag, " bkgd_addr"}, 32'(bus.bkgd_rom_addr), a.baddr);
            end
            if (poke && k == 2) begin
                bus.spr_x  = ($urandom & 32'h3f);
                bus.spr_y  = ($urandom & 32'hf);
                bus.spr_en = 2'($urandom_range(0, 3));
                bus.mode   = 2'($urandom_range(0, 3));
            end
            if (poke && k == 3) bus.start = 1'b1;
            if (k == 4) bus.start = 1'b0;
        end
        chk({tag, " done_cycle"}, done_at, p + LAT + 2);
        chk({tag, " busy_cycles"}, busy_n, p + LAT + 2);
        chk({tag, " plot_count"}, plots_seen - ps0, exp_plots);
        chk({tag, " leftover"}, exp_q.size(), 0);
        adr_q.delete();
    endtask

    // monitor: every plot pops the scoreboard; idle cycles must hold the last pixel
    initial begin
        pix_t e;
        forever begin
            @(negedge clk_50);
            if (bus.plot === 1'b1) begin
                plots_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_plot actual=(%0d,%0d,%0h) required=none",
                             bus.x_out, bus.y_out, bus.colour_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'({bus.x_out, bus.y_out, bus.colour_out}), 32'(e));
                    last_pix = e;
                end
            end else if (reset === 1'b1) begin
                last_pix = '0;
            end else begin
                chk("hold", 32'({bus.x_out, bus.y_out, bus.colour_out}), 32'(last_pix));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        bus.start  = 1'b0;
        bus.mode   = '0;
        bus.spr_en = '0;
        bus.spr_x  = '0;
        bus.spr_y  = '0;
        foreach (bkgd_mem[i]) bkgd_mem[i] = COLW'($urandom);
        foreach (spr_mem[i])  spr_mem[i]  = COLW'($urandom_range(1, 511));
        reset = 1'b1;
        repeat (3) @(negedge clk_50);
        chk("rst plot", 32'(bus.plot), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst xyc", 32'({bus.x_out, bus.y_out, bus.colour_out}), 0);
        chk("rst saddr", 32'(bus.sprite_rom_addr), 0);
        chk("rst baddr", 32'(bus.bkgd_rom_addr), 0);
        reset = 1'b0;

        run_pass("fill", 2'b10, 2'b00, 0, 0, 0, 0, 1'b0);
        run_pass("draw2", 2'b00, 2'b11, 0, 0, 4, 2, 1'b0);
        spr_mem[5] = 9'h000;
        run_pass("transp", 2'b00, 2'b11, 0, 0, 4, 2, 1'b0);
        spr_mem[5] = 9'h1a5;
        run_pass("erase", 2'b01, 2'b10, 0, 0, 2, 1, 1'b0);
        run_pass("edge", 2'b00, 2'b01, 6, 0, 0, 0, 1'b0);
        run_pass("none", 2'b00, 2'b00, 1, 1, 2, 2, 1'b0);

        // abort a FILL pass with reset at cycle 5
        start_pass(2'b10, 2'b00, 0, 0, 0, 0, p);
        repeat (5) @(negedge clk_50);
        reset = 1'b1;
        @(posedge clk_50);
        #1;
        exp_q.delete();
        adr_q.delete();
        @(negedge clk_50);
        chk("abort plot", 32'(bus.plot), 0);
        chk("abort busy", 32'(bus.busy), 0);
        @(negedge clk_50);
        chk("abort done", 32'(bus.done), 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk_50);
            chk("abort idle", 32'({bus.busy, bus.done}), 0);
        end
        run_pass("refill", 2'b11, 2'b00, 0, 0, 0, 0, 1'b0);
        run_pass("busy_start", 2'b00, 2'b11, 1, 0, 3, 1, 1'b1);

        for (int n = 0; n < 12; n++) begin
            foreach (spr_mem[i])  spr_mem[i]  = ($urandom_range(0, 3) == 0) ? 9'h000 : COLW'($urandom);
            foreach (bkgd_mem[i]) bkgd_mem[i] = COLW'($urandom);
            run_pass("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     $urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 7), $urandom_range(0, 3), (n % 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
